// File: rtl/byte_load_sequencer.sv
// Byte-wide memory load sequencer: fetches one or two bytes and writes each,
// zero-padded, to a downstream 16-bit register with a mode-dependent function select.
module byte_load_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Mode,
    input  logic [15:0] StartAddr,
    input  logic [7:0]  MemData,
    input  logic        MemValid,
    output logic        MemRead,
    output logic [15:0] MemAddr,
    output logic [15:0] RegI,
    output logic        RegE,
    output logic [2:0]  RegFunSel,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic        mem_read_q, mem_read_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] reg_i_q, reg_i_d;
    logic        reg_e_q, reg_e_d;
    logic [2:0]  reg_fun_sel_q, reg_fun_sel_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  wait_inc;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        mem_read_d    = mem_read_q;
        mem_addr_d    = mem_addr_q;
        reg_i_d       = reg_i_q;
        reg_e_d       = 1'b0;
        reg_fun_sel_d = reg_fun_sel_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = error_q;
        wait_d        = wait_q;
        wait_inc      = wait_q + 8'd1;

        unique case (state_q)
            IDLE: begin
                busy_d     = 1'b0;
                mem_read_d = 1'b0;
                if (Start) begin
                    if (Mode == 2'b11) begin
                        error_d = 1'b1;
                    end else begin
                        mode_d     = Mode;
                        mem_addr_d = StartAddr;
                        error_d    = 1'b0;
                        wait_d     = '0;
                        mem_read_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = REQ_LO;
                    end
                end
            end
            REQ_LO, REQ_HI: begin
                // REQ_HI is entered with MemRead low: that first cycle is the low-byte write
                if (!mem_read_q) begin
                    mem_read_d = 1'b1;
                    wait_d     = '0;
                end else if (MemValid) begin
                    mem_read_d = 1'b0;
                    reg_e_d    = 1'b1;
                    reg_i_d    = {8'h00, MemData};
                    mem_addr_d = mem_addr_q + 16'd1;
                    wait_d     = '0;
                    if (state_q == REQ_HI) begin
                        reg_fun_sel_d = 3'b110;
                    end else begin
                        unique case (mode_q)
                            2'b01:   reg_fun_sel_d = 3'b101;
                            2'b10:   reg_fun_sel_d = 3'b111;
                            default: reg_fun_sel_d = 3'b100;
                        endcase
                    end
                    if (state_q == REQ_LO && mode_q == 2'b01) begin
                        state_d = REQ_HI;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (wait_inc == TIMEOUT_LIMIT) begin
                    error_d    = 1'b1;
                    mem_read_d = 1'b0;
                    busy_d     = 1'b0;
                    wait_d     = '0;
                    state_d    = IDLE;
                end else begin
                    wait_d = wait_inc;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            mode_q        <= '0;
            mem_read_q    <= 1'b0;
            mem_addr_q    <= '0;
            reg_i_q       <= '0;
            reg_e_q       <= 1'b0;
            reg_fun_sel_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            mem_read_q    <= mem_read_d;
            mem_addr_q    <= mem_addr_d;
            reg_i_q       <= reg_i_d;
            reg_e_q       <= reg_e_d;
            reg_fun_sel_q <= reg_fun_sel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            wait_q        <= wait_d;
        end
    end

    assign MemRead   = mem_read_q;
    assign MemAddr   = mem_addr_q;
    assign RegI      = reg_i_q;
    assign RegE      = reg_e_q;
    assign RegFunSel = reg_fun_sel_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = error_q;

endmodule

// File: tb/tb_byte_load_sequencer.sv
// Directed-vector bench for byte_load_sequencer with hand-computed expectations.
module tb_byte_load_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Mode;
    logic [15:0] StartAddr;
    logic [7:0]  MemData;
    logic        MemValid;
    logic        MemRead;
    logic [15:0] MemAddr;
    logic [15:0] RegI;
    logic        RegE;
    logic [2:0]  RegFunSel;
    logic        Busy;
    logic        Done;
    logic        Error;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic        seen_rege;
    logic        seen_done;

    byte_load_sequencer #(.TIMEOUT_CYCLES(15)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Mode      (Mode),
        .StartAddr (StartAddr),
        .MemData   (MemData),
        .MemValid  (MemValid),
        .MemRead   (MemRead),
        .MemAddr   (MemAddr),
        .RegI      (RegI),
        .RegE      (RegE),
        .RegFunSel (RegFunSel),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge, inputs changed there too.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Mode = 2'b00; StartAddr = 16'h0000;
        MemData = 8'h00; MemValid = 1'b0;
        step(); step();
        Reset = 1'b0;
        chk("rst_memread", 32'(MemRead), 0);
        chk("rst_memaddr", 32'(MemAddr), 0);
        chk("rst_regi", 32'(RegI), 0);
        chk("rst_rege", 32'(RegE), 0);
        chk("rst_funsel", 32'(RegFunSel), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_error", 32'(Error), 0);

        // Word load from 0x0100, each byte valid on the second request cycle
        Start = 1'b1; Mode = 2'b01; StartAddr = 16'h0100;
        step();
        Start = 1'b0;
        chk("w_lo_memread", 32'(MemRead), 1);
        chk("w_lo_busy", 32'(Busy), 1);
        chk("w_lo_addr", 32'(MemAddr), 32'h0100);
        step();
        MemData = 8'h34; MemValid = 1'b1;
        step();
        MemValid = 1'b0;
        chk("w_lo_rege", 32'(RegE), 1);
        chk("w_lo_regi", 32'(RegI), 32'h0034);
        chk("w_lo_funsel", 32'(RegFunSel), 3'b101);
        chk("w_lo_memread_drop", 32'(MemRead), 0);
        chk("w_lo_addr_inc", 32'(MemAddr), 32'h0101);
        Start = 1'b1; Mode = 2'b00; StartAddr = 16'hABCD;
        step();
        Start = 1'b0;
        chk("w_hi_memread", 32'(MemRead), 1);
        chk("w_hi_addr", 32'(MemAddr), 32'h0101);
        chk("w_hi_rege_low", 32'(RegE), 0);
        chk("w_hi_funsel_hold", 32'(RegFunSel), 3'b101);
        step();
        MemData = 8'h12; MemValid = 1'b1;
        step();
        MemValid = 1'b0;
        chk("w_hi_rege", 32'(RegE), 1);
        chk("w_hi_regi", 32'(RegI), 32'h0012);
        chk("w_hi_funsel", 32'(RegFunSel), 3'b110);
        chk("w_done", 32'(Done), 1);
        chk("w_done_busy", 32'(Busy), 0);
        step();
        chk("w_done_once", 32'(Done), 0);
        chk("w_idle_rege", 32'(RegE), 0);
        chk("w_idle_addr", 32'(MemAddr), 32'h0102);
        chk("w_idle_regi_hold", 32'(RegI), 32'h0012);

        // MemValid while idle must be ignored
        MemData = 8'hFF; MemValid = 1'b1;
        step();
        MemValid = 1'b0;
        chk("idle_valid_rege", 32'(RegE), 0);
        chk("idle_valid_regi", 32'(RegI), 32'h0012);

        // Sign-extend byte mode, then zero-extend with the same byte
        Start = 1'b1; Mode = 2'b10; StartAddr = 16'h0200;
        step();
        Start = 1'b0; MemData = 8'h85; MemValid = 1'b1;
        step();
        MemValid = 1'b0;
        chk("sx_rege", 32'(RegE), 1);
        chk("sx_funsel", 32'(RegFunSel), 3'b111);
        chk("sx_regi", 32'(RegI), 32'h0085);
        chk("sx_done", 32'(Done), 1);
        step();
        chk("sx_idle_busy", 32'(Busy), 0);
        Start = 1'b1; Mode = 2'b00; StartAddr = 16'h0200;
        step();
        Start = 1'b0; MemValid = 1'b1;
        step();
        MemValid = 1'b0;
        chk("zx_funsel", 32'(RegFunSel), 3'b100);
        chk("zx_regi", 32'(RegI), 32'h0085);
        step();

        // Timeout: MemValid never arrives
        Start = 1'b1; Mode = 2'b00; StartAddr = 16'h0400;
        step();
        Start = 1'b0;
        seen_rege = 1'b0; seen_done = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            seen_rege |= RegE; seen_done |= Done;
        end
        chk("to_err_early", 32'(Error), 0);
        chk("to_memread_early", 32'(MemRead), 1);
        step();
        seen_rege |= RegE; seen_done |= Done;
        chk("to_error", 32'(Error), 1);
        chk("to_memread", 32'(MemRead), 0);
        chk("to_busy", 32'(Busy), 0);
        chk("to_no_rege", 32'(seen_rege), 0);
        chk("to_no_done", 32'(seen_done), 0);
        step();
        chk("to_error_sticky", 32'(Error), 1);
        chk("to_idle_memread", 32'(MemRead), 0);
        Start = 1'b1; Mode = 2'b00; StartAddr = 16'h0400;
        step();
        Start = 1'b0;
        chk("to_restart_clr", 32'(Error), 0);
        MemData = 8'h5A; MemValid = 1'b1;
        step();
        MemValid = 1'b0;
        step();

        // Address wrap across 0xFFFF
        Start = 1'b1; Mode = 2'b01; StartAddr = 16'hFFFF;
        step();
        Start = 1'b0;
        chk("wrap_addr0", 32'(MemAddr), 32'hFFFF);
        MemData = 8'hAA; MemValid = 1'b1;
        step();
        MemValid = 1'b0;
        chk("wrap_addr_inc", 32'(MemAddr), 32'h0000);
        step();
        chk("wrap_addr1", 32'(MemAddr), 32'h0000);
        chk("wrap_memread1", 32'(MemRead), 1);
        MemData = 8'hBB; MemValid = 1'b1;
        step();
        MemValid = 1'b0;
        chk("wrap_regi_hi", 32'(RegI), 32'h00BB);
        chk("wrap_addr_end", 32'(MemAddr), 32'h0001);
        step();

        // Second Start mid-load ignored, then reset right after low-byte accept
        Start = 1'b1; Mode = 2'b01; StartAddr = 16'h0300;
        step();
        Start = 1'b1; Mode = 2'b10; StartAddr = 16'h9999;
        step();
        Start = 1'b0;
        chk("mid_start_addr", 32'(MemAddr), 32'h0300);
        chk("mid_start_memread", 32'(MemRead), 1);
        MemData = 8'h56; MemValid = 1'b1;
        step();
        chk("mid_lo_funsel", 32'(RegFunSel), 3'b101);
        chk("mid_lo_regi", 32'(RegI), 32'h0056);
        Reset = 1'b1; Start = 1'b1; MemData = 8'h78;
        step();
        Reset = 1'b0; Start = 1'b0; MemValid = 1'b0;
        chk("mr_rege", 32'(RegE), 0);
        chk("mr_regi", 32'(RegI), 0);
        chk("mr_funsel", 32'(RegFunSel), 0);
        chk("mr_memaddr", 32'(MemAddr), 0);
        chk("mr_memread", 32'(MemRead), 0);
        chk("mr_busy", 32'(Busy), 0);
        step();
        chk("mr_after_rege", 32'(RegE), 0);
        chk("mr_after_memread", 32'(MemRead), 0);
        chk("mr_after_done", 32'(Done), 0);

        // Reserved mode
        Start = 1'b1; Mode = 2'b11; StartAddr = 16'h0500;
        step();
        Start = 1'b0;
        chk("rsv_error", 32'(Error), 1);
        chk("rsv_memread", 32'(MemRead), 0);
        chk("rsv_busy", 32'(Busy), 0);
        step();
        chk("rsv_memread2", 32'(MemRead), 0);
        chk("rsv_addr", 32'(MemAddr), 0);
        chk("rsv_error_sticky", 32'(Error), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
